// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_port_arbiter
// Description : Round-robin arbiter sharing one single-port BRAM between a
//               host/message loader (port 0) and the mining controller
//               (port 1). One access in flight; registered BRAM strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int WIDTH_W = 9,
  parameter int WDATA_W = 32,
  parameter int RDATA_W = 512,
  parameter int RD_LAT  = 1
) (
  input  logic               clock,
  input  logic               reset,
  // port 0: host / message loader
  input  logic               req0_valid,
  input  logic               req0_write,
  input  logic [ADDR_W-1:0]  req0_addr,
  input  logic [WIDTH_W-1:0] req0_width,
  input  logic [WDATA_W-1:0] req0_wdata,
  output logic               req0_ready,
  output logic               rsp0_valid,
  output logic [RDATA_W-1:0] rsp0_rdata,
  // port 1: mining controller
  input  logic               req1_valid,
  input  logic               req1_write,
  input  logic [ADDR_W-1:0]  req1_addr,
  input  logic [WIDTH_W-1:0] req1_width,
  input  logic [WDATA_W-1:0] req1_wdata,
  output logic               req1_ready,
  output logic               rsp1_valid,
  output logic [RDATA_W-1:0] rsp1_rdata,
  // BRAM side
  output logic               cs_n,
  output logic               wr_n,
  output logic               rd_n,
  output logic [ADDR_W-1:0]  addr,
  output logic [WIDTH_W-1:0] addr_width,
  output logic [WDATA_W-1:0] bram_data_in,
  input  logic [RDATA_W-1:0] bram_data_out,
  // status
  output logic               busy,
  output logic               grant_id
);

  // Wait counter is sized for the largest supported read latency (15).
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t             state;
  logic               last_grant;
  logic               op_write;
  logic [CNT_W-1:0]   wait_cnt;

  logic               sel_port;
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [WIDTH_W-1:0] sel_width;
  logic [WDATA_W-1:0] sel_wdata;
  logic               accept;

  // Pick the requester: a lone valid port wins, on conflict the port that
  // did not win last time wins. Nothing is accepted while reset is held.
  always_comb begin
    sel_port  = req1_valid & (~req0_valid | ~last_grant);
    sel_write = sel_port ? req1_write : req0_write;
    sel_addr  = sel_port ? req1_addr  : req0_addr;
    sel_width = sel_port ? req1_width : req0_width;
    sel_wdata = sel_port ? req1_wdata : req0_wdata;
    accept    = (state == ST_IDLE) & (req0_valid | req1_valid) & ~reset;
  end

  assign req0_ready = accept & ~sel_port;
  assign req1_ready = accept &  sel_port;

  // Access sequencer: latch on accept, strobe the BRAM, then complete with a
  // one-cycle response pulse on the return to IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      last_grant   <= 1'b1;
      grant_id     <= 1'b0;
      op_write     <= 1'b0;
      wait_cnt     <= '0;
      cs_n         <= 1'b1;
      wr_n         <= 1'b1;
      rd_n         <= 1'b1;
      addr         <= '0;
      addr_width   <= '0;
      bram_data_in <= '0;
      busy         <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp0_rdata   <= '0;
      rsp1_rdata   <= '0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            grant_id     <= sel_port;
            last_grant   <= sel_port;
            op_write     <= sel_write;
            addr         <= sel_addr;
            addr_width   <= sel_width;
            bram_data_in <= sel_wdata;
            // Strobes are registered, so they are low during ISSUE.
            cs_n         <= 1'b0;
            wr_n         <= ~sel_write;
            rd_n         <= sel_write;
            busy         <= 1'b1;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (op_write) begin
            // Single-cycle write; the ack goes out as we leave.
            cs_n       <= 1'b1;
            wr_n       <= 1'b1;
            busy       <= 1'b0;
            rsp0_valid <= ~grant_id;
            rsp1_valid <= grant_id;
            state      <= ST_IDLE;
          end else begin
            wait_cnt <= CNT_W'(RD_LAT);
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - CNT_W'(1);
          if (wait_cnt == CNT_W'(1)) begin
            // Counter hits zero on this edge: read data is valid now.
            if (grant_id) rsp1_rdata <= bram_data_out;
            else          rsp0_rdata <= bram_data_out;
            rsp0_valid <= ~grant_id;
            rsp1_valid <= grant_id;
            cs_n       <= 1'b1;
            rd_n       <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          cs_n  <= 1'b1;
          wr_n  <= 1'b1;
          rd_n  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares the single-port block RAM holding the message blocks and nonce between two requesters.
- Port 0 is the host/message loader; port 1 is the mining controller (chunk fetch, nonce read-modify-write, result readback).
- Drives the BRAM active-low strobes (cs_n/wr_n/rd_n), addr, addr_width and 32-bit write data. Returns the 512-bit read word to the requester that asked for it.
- Round-robin arbitration; one access in flight at a time.

Parameters:
ADDR_W, 16, BRAM word address width
WIDTH_W, 9, bit-select field width (addr_width)
WDATA_W, 32, write data width
RDATA_W, 512, read data width
RD_LAT, 1, BRAM read latency in clocks (1..15)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req0_valid  in  1  port 0 request
req0_write  in  1  1 = write, 0 = read
req0_addr  in  ADDR_W  word address
req0_width  in  WIDTH_W  bit position for write field
req0_wdata  in  WDATA_W  write data
req0_ready  out  1  request accepted this cycle (valid&ready)
rsp0_valid  out  1  one-cycle completion pulse (read data or write ack)
rsp0_rdata  out  RDATA_W  read data, valid with rsp0_valid
req1_valid, req1_write, req1_addr, req1_width, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata: same as port 0
cs_n  out  1  BRAM chip select, active low
wr_n  out  1  BRAM write strobe, active low
rd_n  out  1  BRAM read strobe, active low
addr  out  ADDR_W  BRAM address
addr_width  out  WIDTH_W  BRAM field bit position
bram_data_in  out  WDATA_W  BRAM write data
bram_data_out  in  RDATA_W  BRAM read data
busy  out  1  high whenever state != IDLE
grant_id  out  1  port owning the current/last access

Behaviour:
- Reset (synchronous, high) clears all registers:
  - cs_n=wr_n=rd_n=1; addr=0, addr_width=0, bram_data_in=0
  - rsp*_valid=0, rsp*_rdata=0, busy=0, grant_id=0
  - state=IDLE; last_grant=1, so port 0 wins the first conflict.
- Reset mid-access aborts it: strobes go high on the next edge and no rsp pulse is issued.
- FSM states: IDLE, ISSUE, WAIT, DONE-less (completion happens on the return to IDLE).
- IDLE:
  - req*_ready is combinational: high only in IDLE, for the selected port only.
  - Selection: if exactly one port is valid, that port wins. If both are valid, the port != last_grant wins.
  - On transfer, latch write/addr/width/wdata, set grant_id and last_grant, and go to ISSUE.
- ISSUE (1 cycle):
  - addr, addr_width and bram_data_in are driven from the latch; cs_n=0.
  - Write: wr_n=0, rd_n=1; next state IDLE with rsp_valid=1 for the granted port (write ack).
  - Read: rd_n=0, wr_n=1; load the wait counter with RD_LAT; next state WAIT.
- WAIT:
  - rd_n and cs_n stay low; the counter decrements each cycle.
  - On the edge where the counter reaches 0: capture bram_data_out into the granted port's rsp_rdata, pulse its rsp_valid, deassert strobes, go to IDLE.
- Outputs are registered.
  - addr, addr_width and bram_data_in hold their last value after an access.
  - rsp*_rdata holds until the next read on that port. Write acks do not change rdata.
- Invariants: wr_n and rd_n are never low together. cs_n is low iff wr_n or rd_n is low. Only one rsp*_valid may be high per cycle.
- Timing: accept at cycle T.
  - Write: strobe at T+1, ack at T+2.
  - Read: strobe from T+1 to T+1+RD_LAT, rsp at T+2+RD_LAT.
  - A new accept can occur in the same cycle as the rsp. Back-to-back throughput is 1 write per 2 cycles, or 1 read per RD_LAT+2 cycles.
- Input changes on an unselected port or a non-IDLE cycle are ignored. A requester must hold valid and fields stable until ready.
- addr_width is passed through unchecked. The arbiter does no range or overlap checking.

Test Plan:
- Reset: assert reset 3 cycles during random traffic -> cs_n=wr_n=rd_n=1, addr=0, busy=0, no rsp pulses; first conflict after reset grants port 0.
- Port 0 write addr=0x0005 width=9'd287 wdata=0xDEADBEEF at T -> at T+1 cs_n=0, wr_n=0, addr=0x0005, addr_width=287, bram_data_in=0xDEADBEEF; rsp0_valid at T+2 only.
- Port 1 read addr=0x0002, RD_LAT=1, BRAM model returns 512'hA5... -> rd_n low for T+1..T+2, rsp1_valid at T+3 with rsp1_rdata=512'hA5...; rsp0_valid stays 0.
- Both ports hold valid (reads) for 6 accesses -> grants alternate 0,1,0,1,0,1; no access lost or duplicated.
- Reset asserted in WAIT of a read with RD_LAT=4 -> strobes high next edge, no rsp1_valid, state IDLE.
- Port 0 streams 4 writes with valid held high -> accepts at T, T+2, T+4, T+6; wr_n and rd_n never low together.
